cache_mem_arbiter: RTL and testbench

//   Shares one RAM port between N_CLIENTS cache instances.

---
 rtl/cache_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 28 ++
 rtl/cache_mem_arbiter.sv | 105 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/RAM arbiter: FSM states, memory op and the default block shape.
package cache_arb_pkg;

    localparam int DATA_BITS_DEF   = 32;
    localparam int BLOCK_BITS_DEF  = 2;
    localparam int BLOCK_WORDS_DEF = 2 ** BLOCK_BITS_DEF;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} arb_state_t;
    typedef enum logic {OP_READ, OP_WRITE} mem_op_t;
    typedef logic [BLOCK_WORDS_DEF-1:0][DATA_BITS_DEF-1:0] block_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping to 0.
module rr_pick #(
    parameter int  N_CLIENTS = 2,
    localparam int ID_BITS   = $clog2(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [ID_BITS-1:0]   rr_ptr,
    output logic                 any_req,
    output logic [ID_BITS-1:0]   winner
);

    logic [ID_BITS-1:0] idx;

    // Scan from the farthest offset back to rr_ptr so the closest requester is written last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            idx = ID_BITS'((int'(rr_ptr) + i) % N_CLIENTS);
            if (req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between several cache clients,
// one RAM transaction per grant, with a RESP and a RELEASE cycle after each.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int  N_CLIENTS        = 2,
    parameter int  RAM_ADDRESS_BITS = 32,
    parameter int  DATA_BITS        = DATA_BITS_DEF,
    parameter int  BLOCK_BITS       = BLOCK_BITS_DEF,
    localparam int BLOCK_WORDS      = 2 ** BLOCK_BITS,
    localparam int ID_BITS          = $clog2(N_CLIENTS)
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [N_CLIENTS-1:0][RAM_ADDRESS_BITS-1:0]       cl_address,
    input  logic [N_CLIENTS-1:0]                             cl_read_en,
    input  logic [N_CLIENTS-1:0]                             cl_write_en,
    input  logic [N_CLIENTS-1:0][DATA_BITS-1:0]              cl_write_data,
    output logic [N_CLIENTS-1:0]                             cl_valid,
    output logic [BLOCK_WORDS-1:0][DATA_BITS-1:0]            cl_data,
    output logic [RAM_ADDRESS_BITS-1:0]                      mem_address,
    output logic                                             mem_read_en,
    output logic                                             mem_write_en,
    output logic [DATA_BITS-1:0]                             mem_write_data,
    input  logic                                             mem_valid,
    input  logic [BLOCK_WORDS-1:0][DATA_BITS-1:0]            mem_data,
    output logic [ID_BITS-1:0]                               grant_id
);

    arb_state_t           state;
    logic [ID_BITS-1:0]   rr_ptr;
    logic [N_CLIENTS-1:0] req;
    logic                 any_req;
    logic [ID_BITS-1:0]   winner;
    mem_op_t              op_sel;

    assign req    = cl_read_en | cl_write_en;
    assign op_sel = cl_write_en[winner] ? OP_WRITE : OP_READ;

    rr_pick #(
        .N_CLIENTS (N_CLIENTS)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    function automatic logic [ID_BITS-1:0] next_ptr(input logic [ID_BITS-1:0] id);
        if (int'(id) == N_CLIENTS - 1) begin
            return '0;
        end
        return id + ID_BITS'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant_id       <= '0;
            mem_address    <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
            cl_valid       <= '0;
            cl_data        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Latch the whole request so later client changes cannot disturb the transaction.
                    if (any_req) begin
                        grant_id       <= winner;
                        mem_address    <= cl_address[winner];
                        mem_write_data <= cl_write_data[winner];
                        mem_write_en   <= (op_sel == OP_WRITE);
                        mem_read_en    <= (op_sel == OP_READ);
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_valid) begin
                        cl_data            <= mem_data;
                        mem_read_en        <= 1'b0;
                        mem_write_en       <= 1'b0;
                        cl_valid[grant_id] <= 1'b1;
                        state              <= RESP;
                    end
                end
                RESP: begin
                    cl_valid <= '0;
                    rr_ptr   <= next_ptr(grant_id);
                    state    <= RELEASE;
                end
                RELEASE: begin
                    // Gives the served client one cycle to drop its request before re-arbitration.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random client/RAM traffic checked every cycle
// against a request/grant/response model of the arbiter.
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = DATA_BITS_DEF;
    localparam int BW = BLOCK_WORDS_DEF;
    localparam int IW = $clog2(N);

    logic                 clk;
    logic                 reset;
    logic [N-1:0][AW-1:0] cl_address;
    logic [N-1:0]         cl_read_en;
    logic [N-1:0]         cl_write_en;
    logic [N-1:0][DW-1:0] cl_write_data;
    logic [N-1:0]         cl_valid;
    block_t               cl_data;
    logic [AW-1:0]        mem_address;
    logic                 mem_read_en;
    logic                 mem_write_en;
    logic [DW-1:0]        mem_write_data;
    logic                 mem_valid;
    block_t               mem_data;
    logic [IW-1:0]        grant_id;

    cache_mem_arbiter #(
        .N_CLIENTS        (N),
        .RAM_ADDRESS_BITS (AW),
        .DATA_BITS        (DW),
        .BLOCK_BITS       (BLOCK_BITS_DEF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cl_address     (cl_address),
        .cl_read_en     (cl_read_en),
        .cl_write_en    (cl_write_en),
        .cl_write_data  (cl_write_data),
        .cl_valid       (cl_valid),
        .cl_data        (cl_data),
        .mem_address    (mem_address),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .grant_id       (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who was served last, whether a transaction is open, what it latched.
    int            step_no;
    int            m_last_resp;
    int            m_last_served;
    int            m_grant;
    bit            m_busy;
    bit            m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    block_t        m_data;
    int            glog[$];
    int            served[N];

    // RAM responder and random client controls
    bit     ram_auto, ram_fixed, ram_rand, spur_en;
    int     ram_lat, ram_cnt;
    block_t fixed_block, last_block;
    bit     rand_clients, rand_stop;
    int     idle_cnt[N];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic block_t rnd_block();
        block_t b;
        for (int w = 0; w < BW; w++) b[w] = $urandom;
        return b;
    endfunction

    task automatic model_reset();
        m_busy        = 1'b0;
        m_last_served = N - 1;
        m_grant       = 0;
        m_data        = '0;
        m_last_resp   = -100;
    endtask

    // One clock: predict from the inputs now driven, clock, compare, then update RAM and clients.
    task automatic step();
        bit           e_reset, e_start, e_resp;
        int           e_client;
        block_t       e_data;
        logic [N-1:0] req;
        logic [N-1:0] ev;
        int           op;
        e_reset  = reset;
        e_start  = 1'b0;
        e_resp   = 1'b0;
        e_client = 0;
        e_data   = mem_data;
        req      = cl_read_en | cl_write_en;
        if (!reset) begin
            if (m_busy && mem_valid) begin
                e_resp = 1'b1;
            end else if (!m_busy && step_no >= m_last_resp + 2 && req != '0) begin
                e_start = 1'b1;
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (m_last_served + i) % N;
                    if (req[c]) begin
                        e_client = c;
                        break;
                    end
                end
                m_addr  = cl_address[e_client];
                m_write = cl_write_en[e_client];
                m_wdata = cl_write_data[e_client];
            end
        end

        @(posedge clk);
        #1;
        step_no++;

        if (e_reset) begin
            model_reset();
            check("rst_cl_valid", cl_valid, '0);
            check("rst_cl_data", cl_data, '0);
            check("rst_mem_address", mem_address, '0);
            check("rst_mem_rd", mem_read_en, 1'b0);
            check("rst_mem_wr", mem_write_en, 1'b0);
            check("rst_mem_wdata", mem_write_data, '0);
            check("rst_grant_id", grant_id, '0);
        end else begin
            if (e_start) begin
                m_busy  = 1'b1;
                m_grant = e_client;
                glog.push_back(e_client);
            end
            if (e_resp) begin
                m_busy        = 1'b0;
                m_data        = e_data;
                m_last_resp   = step_no;
                m_last_served = m_grant;
                served[m_grant]++;
            end
            ev = '0;
            if (e_resp) ev[m_grant] = 1'b1;
            check("cl_valid", cl_valid, ev);
            check("cl_data", cl_data, m_data);
            check("mem_read_en", mem_read_en, m_busy && !m_write);
            check("mem_write_en", mem_write_en, m_busy && m_write);
            check("grant_id", grant_id, m_grant);
            if (m_busy) begin
                check("mem_address", mem_address, m_addr);
                if (m_write) check("mem_write_data", mem_write_data, m_wdata);
            end
        end

        if (ram_auto) begin
            if (mem_valid) begin
                mem_valid = 1'b0;
            end else if (mem_read_en || mem_write_en) begin
                ram_cnt++;
                if (ram_cnt >= ram_lat) begin
                    mem_valid  = 1'b1;
                    mem_data   = ram_fixed ? fixed_block : rnd_block();
                    last_block = mem_data;
                    ram_cnt    = 0;
                    if (ram_rand) ram_lat = $urandom_range(1, 4);
                end
            end else begin
                ram_cnt = 0;
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = rnd_block();
                end
            end
        end

        if (rand_clients) begin
            for (int c = 0; c < N; c++) begin
                if (cl_valid[c]) begin
                    if (cl_write_en[c] && cl_read_en[c] && $urandom_range(0, 1) == 1) begin
                        cl_write_en[c] = 1'b0;
                    end else begin
                        cl_read_en[c]  = 1'b0;
                        cl_write_en[c] = 1'b0;
                        idle_cnt[c]    = $urandom_range(0, 3);
                    end
                end else if (!(cl_read_en[c] || cl_write_en[c])) begin
                    if (idle_cnt[c] > 0) begin
                        idle_cnt[c]--;
                    end else if (!rand_stop) begin
                        op               = $urandom_range(0, 2);
                        cl_read_en[c]    = (op != 1);
                        cl_write_en[c]   = (op != 0);
                        cl_address[c]    = $urandom;
                        cl_write_data[c] = $urandom;
                    end
                end else if (m_busy && m_grant == c && $urandom_range(0, 1) == 1) begin
                    cl_address[c]    = $urandom;
                    cl_write_data[c] = $urandom;
                end
            end
        end
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n;
        n = 0;
        while (!(mem_read_en || mem_write_en) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_start"}, mem_read_en || mem_write_en, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input int c, input int budget);
        int n;
        n = 0;
        while (!cl_valid[c] && n < budget) begin
            step();
            n++;
        end
        check({tag, "_valid"}, cl_valid[c], 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 100) begin
            step();
            n++;
        end
        check("drain_idle", mem_read_en || mem_write_en, 1'b0);
        repeat (3) step();
    endtask

    initial begin
        int g0;
        int n;
        reset         = 1'b1;
        cl_address    = '0;
        cl_read_en    = '0;
        cl_write_en   = '0;
        cl_write_data = '0;
        mem_valid     = 1'b0;
        mem_data      = '0;
        ram_auto      = 1'b0;
        ram_fixed     = 1'b0;
        ram_rand      = 1'b0;
        spur_en       = 1'b0;
        ram_lat       = 1;
        ram_cnt       = 0;
        fixed_block   = '0;
        last_block    = '0;
        rand_clients  = 1'b0;
        rand_stop     = 1'b0;
        step_no       = 0;
        for (int c = 0; c < N; c++) begin
            served[c]   = 0;
            idle_cnt[c] = 0;
        end
        model_reset();

        // Reset held with requests and mem_valid active
        cl_read_en    = '1;
        cl_write_en   = 2'b10;
        cl_address[0] = 32'h10000;
        cl_address[1] = 32'h20000;
        mem_valid     = 1'b1;
        mem_data      = rnd_block();
        step();
        step();
        reset       = 1'b0;
        cl_read_en  = '0;
        cl_write_en = '0;
        mem_valid   = 1'b0;
        step();
        check("t1_no_mem", mem_read_en || mem_write_en, 1'b0);

        // Single read from client 0
        ram_auto      = 1'b1;
        ram_fixed     = 1'b1;
        ram_lat       = 3;
        fixed_block   = {BW{32'h2}};
        cl_address[0] = 32'h10000;
        cl_read_en[0] = 1'b1;
        step();
        check("t2_addr", mem_address, 32'h10000);
        check("t2_rd", mem_read_en, 1'b1);
        wait_valid("t2", 0, 20);
        check("t2_data", cl_data, {BW{32'h2}});
        check("t2_other", cl_valid[1], 1'b0);
        cl_read_en[0] = 1'b0;
        step();
        check("t2_pulse", cl_valid[0], 1'b0);
        drain();

        // Round-robin with both clients reading continuously
        reset = 1'b1;
        step();
        reset         = 1'b0;
        ram_fixed     = 1'b0;
        ram_lat       = 1;
        g0            = glog.size();
        cl_address[0] = 32'h10000;
        cl_address[1] = 32'h20000;
        cl_read_en    = '1;
        repeat (24) step();
        cl_read_en = '0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t3_grant%0d", j), (g0 + j < glog.size()) ? glog[g0 + j] : -1, j % 2);
        end
        drain();

        // Write has priority; the leftover read becomes a second transaction
        cl_address[1]    = 32'h30000;
        cl_write_data[1] = 32'haaaa;
        cl_write_en[1]   = 1'b1;
        cl_read_en[1]    = 1'b1;
        wait_start("t4w", 10);
        check("t4_wr", mem_write_en, 1'b1);
        check("t4_rd", mem_read_en, 1'b0);
        check("t4_wdata", mem_write_data, 32'haaaa);
        check("t4_id", grant_id, 1);
        wait_valid("t4w", 1, 20);
        cl_write_en[1] = 1'b0;
        wait_start("t4r", 10);
        check("t4_rd2", mem_read_en, 1'b1);
        check("t4_wr2", mem_write_en, 1'b0);
        check("t4_addr2", mem_address, 32'h30000);
        wait_valid("t4r", 1, 20);
        cl_read_en[1] = 1'b0;
        drain();

        // Latched address survives client changes; stray mem_valid in IDLE is ignored
        ram_lat       = 5;
        cl_address[0] = 32'h10000;
        cl_read_en[0] = 1'b1;
        wait_start("t5", 10);
        cl_address[0] = 32'h40000;
        repeat (3) begin
            step();
            check("t5_hold", mem_address, 32'h10000);
        end
        wait_valid("t5", 0, 20);
        cl_read_en[0] = 1'b0;
        drain();
        ram_auto  = 1'b0;
        mem_valid = 1'b1;
        mem_data  = {BW{32'hdeadbeef}};
        step();
        mem_valid = 1'b0;
        check("t5_spur_valid", cl_valid, '0);
        check("t5_spur_data", cl_data, last_block);
        step();
        ram_auto = 1'b1;

        // Reset in the middle of BUSY drops the transaction and restarts from client 0
        ram_lat       = 40;
        cl_address[1] = 32'h60000;
        cl_read_en[1] = 1'b1;
        wait_start("t6", 10);
        check("t6_id", grant_id, 1);
        cl_address[0] = 32'h70000;
        cl_read_en[0] = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        check("t6_rst_rd", mem_read_en, 1'b0);
        check("t6_rst_addr", mem_address, '0);
        check("t6_rst_id", grant_id, 0);
        reset   = 1'b0;
        ram_lat = 2;
        wait_start("t6re", 10);
        check("t6_regrant", grant_id, 0);
        check("t6_readdr", mem_address, 32'h70000);
        wait_valid("t6a", 0, 20);
        cl_read_en[0] = 1'b0;
        wait_start("t6b", 10);
        check("t6_second", grant_id, 1);
        wait_valid("t6b", 1, 20);
        cl_read_en[1] = 1'b0;
        drain();

        // Random traffic with random latency and stray mem_valid pulses
        served[0]    = 0;
        served[1]    = 0;
        rand_clients = 1'b1;
        ram_rand     = 1'b1;
        spur_en      = 1'b1;
        repeat (1500) step();
        rand_stop = 1'b1;
        spur_en   = 1'b0;
        n = 0;
        while (((cl_read_en | cl_write_en) != '0 || m_busy) && n < 300) begin
            step();
            n++;
        end
        check("t7_quiesce", cl_read_en | cl_write_en, '0);
        check("t7_served0", served[0] > 20, 1'b1);
        check("t7_served1", served[1] > 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
